text_memory_loader: RTL and testbench

Boot-time writer for the instruction (text) memory. It accepts a framed little-endian byte stream over a valid/ready handshake and assembles the bytes into 32-bit words. It writes those words to sequential word addresses from 0 through the text memory's write port, and holds the core in reset while loading. Placed between the host link (UART/JTAG byte source) and the text memory; lets programs be swapped without rebuilding the hex image.

---
 rtl/text_loader_pkg.sv | 23 ++
 rtl/text_memory_loader_byte_word_packer.sv | 42 ++++
 rtl/text_memory_loader.sv | 148 ++++++++++++++
 tb/tb_text_memory_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/text_loader_pkg.sv
// Shared types and constants for the boot-time text memory loader.
package text_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_SUM,
    ST_FIN
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  // Frame is good when the data-byte sum plus the trailing checksum byte wraps to zero.
  function automatic logic sum_ok(input logic [7:0] i_acc, input logic [7:0] i_chk);
    logic [7:0] w_total;
    w_total = i_acc + i_chk;
    return (w_total == 8'h00);
  endfunction

endpackage

// File: rtl/text_memory_loader_byte_word_packer.sv
// Little-endian byte-to-word assembler; lane chosen by a 2-bit byte counter.
module byte_word_packer
  import text_loader_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_nxt,
  output logic        o_last
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // o_word_nxt already contains the byte being accepted, so the caller can act on a full word at the same edge.
  always_comb begin
    o_word_nxt = r_word;
    case (r_cnt)
      2'd0:    o_word_nxt[7:0]   = i_byte;
      2'd1:    o_word_nxt[15:8]  = i_byte;
      2'd2:    o_word_nxt[23:16] = i_byte;
      default: o_word_nxt[31:24] = i_byte;
    endcase
  end

  assign o_last = i_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
    end else if (i_en) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= o_word_nxt;
    end
  end

endmodule

// File: rtl/text_memory_loader.sv
// Loads a framed byte stream into text memory word by word, holding the core in reset meanwhile.
module text_memory_loader
  import text_loader_pkg::*;
#(
  parameter int TEXT_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [TEXT_BITS-3:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int          AW        = TEXT_BITS - 2;
  localparam int          CW        = TEXT_BITS - 1;
  localparam logic [31:0] MAX_WORDS = 32'(2 ** AW);

  state_t          r_state, w_state_nxt;
  logic            r_rx_ready, r_wr_en, r_busy, r_done;
  logic            w_rx_ready, w_wr_en, w_busy, w_done;
  logic [CW-1:0]   r_len, r_wcnt, w_wcnt_inc;
  logic [7:0]      r_sum;
  logic            r_error, r_hold;
  logic [AW-1:0]   r_wr_addr;
  logic [31:0]     r_wr_data;
  logic            w_acc, w_pack_en, w_last;
  logic [31:0]     w_word_nxt;

  assign w_acc      = rx_valid && r_rx_ready;
  assign w_pack_en  = w_acc && ((r_state == ST_HDR) || (r_state == ST_DATA));
  assign w_wcnt_inc = r_wcnt + CW'(1);

  byte_word_packer u_packer (
    .i_clock    (clock),
    .i_reset_n  (reset),
    .i_clear    (r_state == ST_IDLE),
    .i_en       (w_pack_en),
    .i_byte     (rx_data),
    .o_word_nxt (w_word_nxt),
    .o_last     (w_last)
  );

  // Control outputs are decoded from the next state and registered with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= w_rx_ready;
      r_wr_en    <= w_wr_en;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_HDR;
      ST_HDR: begin
        if (w_last) begin
          if (w_word_nxt == 32'd0)           w_state_nxt = ST_SUM;
          else if (w_word_nxt > MAX_WORDS)   w_state_nxt = ST_FIN;
          else                               w_state_nxt = ST_DATA;
        end
      end
      ST_DATA:  if (w_last) w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = (w_wcnt_inc == r_len) ? ST_SUM : ST_DATA;
      ST_SUM:   if (w_acc) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rx_ready = (w_state_nxt == ST_HDR) || (w_state_nxt == ST_DATA) || (w_state_nxt == ST_SUM);
    w_wr_en    = (w_state_nxt == ST_WRITE);
    w_busy     = (w_state_nxt != ST_IDLE);
    w_done     = (w_state_nxt == ST_FIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len     <= '0;
      r_wcnt    <= '0;
      r_sum     <= 8'd0;
      r_error   <= 1'b0;
      r_hold    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            r_hold  <= 1'b1;
            r_sum   <= 8'd0;
            r_wcnt  <= '0;
          end
        end
        ST_HDR: begin
          if (w_last) begin
            r_len <= w_word_nxt[CW-1:0];
            if (w_word_nxt > MAX_WORDS) r_error <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_acc) begin
            r_sum <= r_sum + rx_data;
            if (w_last) begin
              r_wr_addr <= r_wcnt[AW-1:0];
              r_wr_data <= w_word_nxt;
            end
          end
        end
        ST_WRITE: r_wcnt <= w_wcnt_inc;
        ST_SUM: begin
          if (w_acc && !sum_ok(r_sum, rx_data)) r_error <= 1'b1;
        end
        // Hold is released on the way back to IDLE only for a clean frame.
        ST_FIN:   r_hold <= r_error;
        default: ;
      endcase
    end
  end

  assign rx_ready = r_rx_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_text_memory_loader.sv
// Directed bench for text_memory_loader: good, bad, empty, oversize, stalled and reset-interrupted frames.
module tb_text_memory_loader;

  localparam int TB_TEXT_BITS = 10;
  localparam int AW           = TB_TEXT_BITS - 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, wr_en, cpu_hold, busy, done, error;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rdy_bad = 0;
  logic [7:0]    frm[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  text_memory_loader #(.TEXT_BITS(TB_TEXT_BITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (wr_en && rx_ready) rdy_bad++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 0);
    check({tag, "_wr_en"},    32'(wr_en),    0);
    check({tag, "_wr_addr"},  32'(wr_addr),  0);
    check({tag, "_wr_data"},  wr_data,       0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_done"},     32'(done),     0);
    check({tag, "_error"},    32'(error),    0);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    rdy_bad  = 0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_hold_rise"}, 32'(cpu_hold), 1);
    check({tag, "_busy_rise"}, 32'(busy), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (rx_ready) ok = 1'b1;
      @(negedge clock);
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit gaps, input int start_at, input bit chk_lat);
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps) repeat (i % 3) @(negedge clock);
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      send_byte(frm[i]);
      if (chk_lat && i >= 4 && ((i - 4) % 4) == 3 && i < frm.size() - 1) begin
        check("wr_en_latency", 32'(wr_en), 1);
        check("wr_addr_latency", 32'(wr_addr), 32'((i - 4) / 4));
      end
    end
  endtask

  task automatic end_frame(input string tag, input logic exp_err, input logic exp_hold, input int exp_nwr);
    check({tag, "_done"},     32'(done), 1);
    check({tag, "_error"},    32'(error), 32'(exp_err));
    check({tag, "_rdy_fin"},  32'(rx_ready), 0);
    check({tag, "_hold_fin"}, 32'(cpu_hold), 1);
    @(negedge clock);
    check({tag, "_done_drop"}, 32'(done), 0);
    check({tag, "_busy_idle"}, 32'(busy), 0);
    check({tag, "_hold_idle"}, 32'(cpu_hold), 32'(exp_hold));
    check({tag, "_n_writes"},  32'(wa_q.size()), 32'(exp_nwr));
    check({tag, "_done_cnt"},  32'(done_cnt), 1);
    check({tag, "_rdy_in_wr"}, 32'(rdy_bad), 0);
  endtask

  task automatic check_two_words(input string tag);
    if (wa_q.size() == 2) begin
      check({tag, "_addr0"}, 32'(wa_q[0]), 0);
      check({tag, "_data0"}, wd_q[0], 32'h0000_0013);
      check({tag, "_addr1"}, 32'(wa_q[1]), 1);
      check({tag, "_data1"}, wd_q[1], 32'h0000_006F);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sum;

    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    // good two-word load
    clear_log();
    frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    pulse_start("good");
    send_frame(1'b0, -1, 1'b1);
    end_frame("good", 1'b0, 1'b0, 2);
    check_two_words("good");

    // bad checksum: writes still happen, error sticks, hold stays
    clear_log();
    frm[12] = 8'h7F;
    pulse_start("badsum");
    send_frame(1'b0, -1, 1'b0);
    end_frame("badsum", 1'b1, 1'b1, 2);
    check_two_words("badsum");
    @(negedge clock);
    check("badsum_hold_sticky", 32'(cpu_hold), 1);
    check("badsum_err_sticky", 32'(error), 1);

    // next start clears error; this frame runs with gaps and a start pulse while busy
    clear_log();
    frm[12] = 8'h7E;
    pulse_start("gaps");
    check("gaps_err_cleared", 32'(error), 0);
    send_frame(1'b1, 2, 1'b1);
    end_frame("gaps", 1'b0, 1'b0, 2);
    check_two_words("gaps");

    // empty program
    clear_log();
    frm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start("len0");
    send_frame(1'b0, -1, 1'b0);
    end_frame("len0", 1'b0, 1'b0, 0);

    // length MAX_WORDS+1 rejected right after the header
    clear_log();
    frm = '{8'h01, 8'h01, 8'h00, 8'h00};
    pulse_start("toobig");
    send_frame(1'b0, -1, 1'b0);
    end_frame("toobig", 1'b1, 1'b1, 0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      check("toobig_rdy_low", 32'(rx_ready), 0);
      @(negedge clock);
    end
    rx_valid = 1'b0;
    check("toobig_busy_low", 32'(busy), 0);

    // length exactly MAX_WORDS completes without counter wrap
    clear_log();
    frm = '{8'h00, 8'h01, 8'h00, 8'h00};
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      frm.push_back(8'(i));
      frm.push_back(8'hA5);
      frm.push_back(8'h00);
      frm.push_back(8'h00);
      sum = sum + 8'(i) + 8'hA5;
    end
    frm.push_back(8'h00 - sum);
    pulse_start("max");
    send_frame(1'b0, -1, 1'b0);
    end_frame("max", 1'b0, 1'b0, 256);
    if (wa_q.size() == 256) begin
      check("max_first_data", wd_q[0], 32'h0000_A500);
      check("max_last_addr", 32'(wa_q[255]), 255);
      check("max_last_data", wd_q[255], 32'h0000_A5FF);
    end

    // async reset after six data bytes, then a clean reload
    frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    pulse_start("rst");
    for (int i = 0; i < 10; i++) send_byte(frm[i]);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    clear_log();
    pulse_start("reload");
    send_frame(1'b0, -1, 1'b1);
    end_frame("reload", 1'b0, 1'b0, 2);
    check_two_words("reload");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
